// File: rtl/instruction_memory_pkg.sv
// Shared widths and the power-on program image for the instruction memory.
package instruction_memory_pkg;

    localparam int unsigned DEF_ADDR_W  = 8;
    localparam int unsigned DEF_INSTR_W = 24;
    localparam int unsigned IMAGE_LEN   = 8;

    localparam logic [DEF_INSTR_W-1:0] DEFAULT_IMAGE [IMAGE_LEN] = '{
        24'h100005,
        24'h200103,
        24'h310200,
        24'h400302,
        24'h500401,
        24'h610502,
        24'h700600,
        24'hF00000
    };

endpackage

// File: rtl/imem_default_rom.sv
// Address-to-default-word lookup; addresses beyond the image return zero.
module imem_default_rom
    import instruction_memory_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W
) (
    input  logic [ADDR_W-1:0]  addr,
    output logic [INSTR_W-1:0] word_c
);

    always_comb begin
        word_c = '0;
        for (int unsigned i = 0; i < IMAGE_LEN; i++) begin
            if (addr == ADDR_W'(i)) begin
                word_c = INSTR_W'(DEFAULT_IMAGE[i]);
            end
        end
    end

endmodule

// File: rtl/instruction_memory.sv
// Flop-based instruction store: combinational read at PC, clocked program load,
// synchronous reset reloads the default program image into every entry.
module instruction_memory
    import instruction_memory_pkg::*;
#(
    parameter int unsigned ADDR_W  = DEF_ADDR_W,
    parameter int unsigned INSTR_W = DEF_INSTR_W,
    parameter int unsigned DEPTH   = 2 ** ADDR_W
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [ADDR_W-1:0]  PC,
    output logic [INSTR_W-1:0] Instr,
    input  logic               prog_we,
    input  logic [ADDR_W-1:0]  prog_addr,
    input  logic [INSTR_W-1:0] prog_data
);

    logic [INSTR_W-1:0] mem [DEPTH];

    // One entry per address: reset mux from the ROM, else decoded program write.
    for (genvar g = 0; g < DEPTH; g++) begin : g_entry
        logic [INSTR_W-1:0] dflt;
        logic [INSTR_W-1:0] q;
        logic               wen;

        imem_default_rom #(
            .ADDR_W  (ADDR_W),
            .INSTR_W (INSTR_W)
        ) u_rom (
            .addr   (ADDR_W'(g)),
            .word_c (dflt)
        );

        assign wen = prog_we && (prog_addr == ADDR_W'(g));

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                q <= dflt;
            end else if (wen) begin
                q <= prog_data;
            end
        end

        assign mem[g] = q;
    end

    // Zero-latency read; an out-of-array PC (only possible with DEPTH < 2**ADDR_W) reads zero.
    always_comb begin
        Instr = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (PC == ADDR_W'(i)) begin
                Instr = mem[i];
            end
        end
    end

endmodule

// File: tb/tb_instruction_memory.sv
// Directed bench for instruction_memory with a queued scoreboard and a decoupled monitor.
module tb_instruction_memory;

    localparam int unsigned ADDR_W  = 8;
    localparam int unsigned INSTR_W = 24;

    logic               clk;
    logic               rst_n;
    logic [ADDR_W-1:0]  PC;
    logic [INSTR_W-1:0] Instr;
    logic               prog_we;
    logic [ADDR_W-1:0]  prog_addr;
    logic [INSTR_W-1:0] prog_data;

    int vectors;
    int miscompares;

    logic [INSTR_W-1:0] exp_q  [$];
    logic [ADDR_W-1:0]  pc_q   [$];
    string              name_q [$];

    logic [INSTR_W-1:0] golden [8];

    instruction_memory #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .DEPTH   (256)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .PC        (PC),
        .Instr     (Instr),
        .prog_we   (prog_we),
        .prog_addr (prog_addr),
        .prog_data (prog_data)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    // Drive PC, queue the expected word; the monitor samples 2 ns later.
    task automatic probe(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] e, input string nm);
        PC = a;
        exp_q.push_back(e);
        pc_q.push_back(a);
        name_q.push_back(nm);
        #4;
    endtask

    task automatic write_word(input logic [ADDR_W-1:0] a, input logic [INSTR_W-1:0] d);
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = a;
        prog_data = d;
        @(posedge clk);
        #1;
        prog_we   = 1'b0;
    endtask

    // Monitor: pops one expectation per presented read and compares it.
    initial begin : monitor
        logic [INSTR_W-1:0] e;
        logic [ADDR_W-1:0]  a;
        string              nm;
        forever begin
            wait (exp_q.size() != 0);
            #2;
            e  = exp_q.pop_front();
            a  = pc_q.pop_front();
            nm = name_q.pop_front();
            vectors++;
            if (Instr !== e) begin
                miscompares++;
                $display("FAIL %s: PC=%0d Instr=%06h expected %06h", nm, a, Instr, e);
            end
        end
    end

    initial begin : stimulus
        vectors     = 0;
        miscompares = 0;
        golden = '{24'h100005, 24'h200103, 24'h310200, 24'h400302,
                   24'h500401, 24'h610502, 24'h700600, 24'hF00000};
        rst_n     = 1'b0;
        prog_we   = 1'b0;
        prog_addr = '0;
        prog_data = '0;
        PC        = '0;

        // One reset edge, then sweep the default image
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            probe(ADDR_W'(i), golden[i], "reset_image");
        end
        @(negedge clk);
        probe(8'd8, 24'h000000, "reset_zero_8");
        probe(8'd255, 24'h000000, "reset_zero_255");

        // Read-during-write: old word before the edge, new word right after
        @(negedge clk);
        prog_we   = 1'b1;
        prog_addr = 8'd3;
        prog_data = 24'hABCDEF;
        probe(8'd3, 24'h400302, "rdw_old");
        @(posedge clk);
        #1;
        prog_we = 1'b0;
        probe(8'd3, 24'hABCDEF, "rdw_new");
        probe(8'd4, 24'h500401, "rdw_neighbor");

        // Top address write
        write_word(8'd255, 24'h123456);
        probe(8'd255, 24'h123456, "write_top");
        probe(8'd0, 24'h100005, "write_top_pc0");

        // No write with prog_we low, even with address/data toggling across edges
        @(negedge clk);
        prog_addr = 8'd5;
        prog_data = 24'h0BAD00;
        @(posedge clk);
        #1;
        prog_addr = 8'd6;
        @(posedge clk);
        #1;
        probe(8'd5, 24'h610502, "we_low_5");
        probe(8'd6, 24'h700600, "we_low_6");

        // Reset overrides a simultaneous write and restores earlier writes
        @(negedge clk);
        rst_n     = 1'b0;
        prog_we   = 1'b1;
        prog_addr = 8'd0;
        prog_data = 24'hFFFFFF;
        @(posedge clk);
        #1;
        rst_n   = 1'b1;
        prog_we = 1'b0;
        probe(8'd0, 24'h100005, "rst_beats_we");
        probe(8'd3, 24'h400302, "rst_restore_3");
        probe(8'd255, 24'h000000, "rst_restore_255");

        // Load several entries, confirm, then one reset edge restores everything
        write_word(8'd1, 24'h111111);
        write_word(8'd7, 24'h777777);
        write_word(8'd100, 24'hC0FFEE);
        probe(8'd1, 24'h111111, "load_1");
        probe(8'd7, 24'h777777, "load_7");
        probe(8'd100, 24'hC0FFEE, "load_100");
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            probe(ADDR_W'(i), golden[i], "reload_image");
        end
        probe(8'd100, 24'h000000, "reload_100");
        probe(8'd255, 24'h000000, "reload_255");

        // Let the monitor drain, bounded
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) #5;
        if (exp_q.size() != 0) begin
            miscompares++;
            $display("FAIL drain: %0d expectations left unchecked, expected 0", exp_q.size());
        end
        #5;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
